// File: rtl/ram_stream_ctrl.sv
// ram_stream_ctrl
// Port-side initiator for the dual-port coefficient RAM. A LOAD pass takes
// DEPTH words from the inbound valid/ready stream and writes them to the RAM
// two at a time: the even word goes to port A and the odd word to port B. An
// UNLOAD pass reads the RAM two words per access and sends them out in address
// order on the outbound valid/ready stream.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_start_load/unload     pass requests, sampled only while idle (load wins)
//   o_busy, o_done          pass in progress / one-cycle completion pulse
//   i_s_data/valid, o_s_ready    inbound word stream
//   o_m_data/valid, i_m_ready    outbound word stream
//   o_ram_addr_a/b, o_ram_din_a/b, o_ram_we_a/b   RAM port A (even) / B (odd)
//   i_ram_dout_a/b          RAM read data, one-cycle read latency
module ram_stream_ctrl #(
  parameter int AWID  = 8,
  parameter int WID   = 16,
  parameter int DEPTH = 1 << AWID
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start_load,
  input  logic            i_start_unload,
  output logic            o_busy,
  output logic            o_done,
  input  logic [WID-1:0]  i_s_data,
  input  logic            i_s_valid,
  output logic            o_s_ready,
  output logic [WID-1:0]  o_m_data,
  output logic            o_m_valid,
  input  logic            i_m_ready,
  output logic [AWID-1:0] o_ram_addr_a,
  output logic [AWID-1:0] o_ram_addr_b,
  output logic [WID-1:0]  o_ram_din_a,
  output logic [WID-1:0]  o_ram_din_b,
  output logic            o_ram_we_a,
  output logic            o_ram_we_b,
  input  logic [WID-1:0]  i_ram_dout_a,
  input  logic [WID-1:0]  i_ram_dout_b
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  localparam logic [AWID-1:0] W_LAST = AWID'(DEPTH - 1);
  localparam logic [AWID-2:0] P_LAST = (AWID-1)'(DEPTH / 2 - 1);

  state_t            r_state,    w_state_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_done,     w_done_nxt;
  logic              r_s_ready,  w_s_ready_nxt;
  logic [AWID-1:0]   r_w,        w_w_nxt;       // LOAD word index
  logic [WID-1:0]    r_hold,     w_hold_nxt;    // even word waiting for its pair
  logic [AWID-1:0]   r_addr_a,   w_addr_a_nxt;
  logic [AWID-1:0]   r_addr_b,   w_addr_b_nxt;
  logic [WID-1:0]    r_din_a,    w_din_a_nxt;
  logic [WID-1:0]    r_din_b,    w_din_b_nxt;
  logic              r_we,       w_we_nxt;
  logic [AWID-2:0]   r_p,        w_p_nxt;       // UNLOAD pair index
  logic              r_first,    w_first_nxt;   // first UNLOAD cycle: drive pair 0
  logic              r_addr_new, w_addr_new_nxt;// address changed last edge
  logic              r_dv,       w_dv_nxt;      // RAM dout reflects current pair
  logic              r_last_cap, w_last_cap_nxt;// final pair is in the buffer
  logic [WID-1:0]    r_m_data,   w_m_data_nxt;
  logic [WID-1:0]    r_buf_b,    w_buf_b_nxt;
  logic              r_sel,      w_sel_nxt;     // 0: A word showing, 1: B word
  logic              r_m_valid,  w_m_valid_nxt;

  logic              w_s_hs;
  logic              w_m_hs;
  logic              w_cap;
  logic [AWID-2:0]   w_p_inc;

  assign w_s_hs  = i_s_valid & r_s_ready;
  assign w_m_hs  = r_m_valid & i_m_ready;
  // A new pair may enter the buffer when it is empty or its last word leaves now.
  assign w_cap   = r_dv & (~r_m_valid | (w_m_hs & r_sel));
  assign w_p_inc = r_p + (AWID-1)'(1);

  // Next-state and next-register computation for all three pass states.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_s_ready_nxt  = r_s_ready;
    w_w_nxt        = r_w;
    w_hold_nxt     = r_hold;
    w_addr_a_nxt   = r_addr_a;
    w_addr_b_nxt   = r_addr_b;
    w_din_a_nxt    = r_din_a;
    w_din_b_nxt    = r_din_b;
    w_we_nxt       = 1'b0;
    w_p_nxt        = r_p;
    w_first_nxt    = r_first;
    w_addr_new_nxt = 1'b0;
    w_dv_nxt       = r_dv;
    w_last_cap_nxt = r_last_cap;
    w_m_data_nxt   = r_m_data;
    w_buf_b_nxt    = r_buf_b;
    w_sel_nxt      = r_sel;
    w_m_valid_nxt  = r_m_valid;

    case (r_state)
      ST_IDLE: begin
        if (i_start_load) begin
          w_state_nxt   = ST_LOAD;
          w_busy_nxt    = 1'b1;
          w_s_ready_nxt = 1'b1;
          w_w_nxt       = '0;
        end else if (i_start_unload) begin
          w_state_nxt    = ST_UNLOAD;
          w_busy_nxt     = 1'b1;
          w_p_nxt        = '0;
          w_first_nxt    = 1'b1;
          w_dv_nxt       = 1'b0;
          w_last_cap_nxt = 1'b0;
          w_sel_nxt      = 1'b0;
          w_m_valid_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (r_done) begin
          // Final write cycle just ended.
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (w_s_hs) begin
          if (!r_w[0]) begin
            w_hold_nxt = i_s_data;
          end else begin
            w_we_nxt     = 1'b1;
            w_addr_a_nxt = {r_w[AWID-1:1], 1'b0};
            w_addr_b_nxt = r_w;
            w_din_a_nxt  = r_hold;
            w_din_b_nxt  = i_s_data;
          end
          if (r_w == W_LAST) begin
            w_s_ready_nxt = 1'b0;
            w_done_nxt    = 1'b1;
          end else begin
            w_w_nxt = r_w + AWID'(1);
          end
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end

      ST_UNLOAD: begin
        if (r_first) begin
          w_first_nxt    = 1'b0;
          w_addr_a_nxt   = {r_p, 1'b0};
          w_addr_b_nxt   = {r_p, 1'b1};
          w_addr_new_nxt = 1'b1;
        end else begin
          // dv rises one cycle after the address moves; a capture consumes it.
          if (w_cap) begin
            w_dv_nxt = 1'b0;
          end else if (r_addr_new) begin
            w_dv_nxt = 1'b1;
          end else begin
            w_dv_nxt = r_dv;
          end

          if (w_cap) begin
            w_m_data_nxt  = i_ram_dout_a;
            w_buf_b_nxt   = i_ram_dout_b;
            w_m_valid_nxt = 1'b1;
            w_sel_nxt     = 1'b0;
            if (r_p == P_LAST) begin
              w_last_cap_nxt = 1'b1;
            end else begin
              w_p_nxt        = w_p_inc;
              w_addr_a_nxt   = {w_p_inc, 1'b0};
              w_addr_b_nxt   = {w_p_inc, 1'b1};
              w_addr_new_nxt = 1'b1;
            end
          end else if (w_m_hs) begin
            if (!r_sel) begin
              w_m_data_nxt = r_buf_b;
              w_sel_nxt    = 1'b1;
            end else begin
              w_m_valid_nxt = 1'b0;
              if (r_last_cap) begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
              end else begin
                w_state_nxt = ST_UNLOAD;
              end
            end
          end else begin
            w_state_nxt = ST_UNLOAD;
          end
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_busy_nxt    = 1'b0;
        w_s_ready_nxt = 1'b0;
        w_m_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears every output and flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_s_ready  <= 1'b0;
      r_w        <= '0;
      r_hold     <= '0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_din_a    <= '0;
      r_din_b    <= '0;
      r_we       <= 1'b0;
      r_p        <= '0;
      r_first    <= 1'b0;
      r_addr_new <= 1'b0;
      r_dv       <= 1'b0;
      r_last_cap <= 1'b0;
      r_m_data   <= '0;
      r_buf_b    <= '0;
      r_sel      <= 1'b0;
      r_m_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_s_ready  <= w_s_ready_nxt;
      r_w        <= w_w_nxt;
      r_hold     <= w_hold_nxt;
      r_addr_a   <= w_addr_a_nxt;
      r_addr_b   <= w_addr_b_nxt;
      r_din_a    <= w_din_a_nxt;
      r_din_b    <= w_din_b_nxt;
      r_we       <= w_we_nxt;
      r_p        <= w_p_nxt;
      r_first    <= w_first_nxt;
      r_addr_new <= w_addr_new_nxt;
      r_dv       <= w_dv_nxt;
      r_last_cap <= w_last_cap_nxt;
      r_m_data   <= w_m_data_nxt;
      r_buf_b    <= w_buf_b_nxt;
      r_sel      <= w_sel_nxt;
      r_m_valid  <= w_m_valid_nxt;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_s_ready    = r_s_ready;
  assign o_m_data     = r_m_data;
  assign o_m_valid    = r_m_valid;
  assign o_ram_addr_a = r_addr_a;
  assign o_ram_addr_b = r_addr_b;
  assign o_ram_din_a  = r_din_a;
  assign o_ram_din_b  = r_din_b;
  assign o_ram_we_a   = r_we;
  assign o_ram_we_b   = r_we;

endmodule

// File: doc/ram_stream_ctrl.md
Name: ram_stream_ctrl

Overview:
Port-side initiator for the 256x16 dual-port coefficient RAM. It fills the RAM from an incoming valid/ready word stream and drains the RAM back out to an outgoing valid/ready stream.
Words are paired so that each RAM access moves two words: the even address goes on port A and the odd address on port B. The block sits between the host-side stream wrappers and the NTT coefficient RAM.

Parameters:
AWID, 8, RAM address width
WID, 16, data word width
DEPTH, 1<<AWID, words per full load/unload (must be even)

Ports:
clk  in  1  clock, all flops on rising edge
rst  in  1  asynchronous active-high reset
start_load  in  1  begin a LOAD pass (sampled in IDLE only)
start_unload  in  1  begin an UNLOAD pass (sampled in IDLE only)
busy  out  1  high while in LOAD or UNLOAD
done  out  1  one-cycle pulse when a pass completes
s_data  in  WID  inbound word
s_valid  in  1  inbound word valid
s_ready  out  1  controller accepts inbound word
m_data  out  WID  outbound word
m_valid  out  1  outbound word valid
m_ready  in  1  sink accepts outbound word
ram_addr_a  out  AWID  RAM port A address (even)
ram_addr_b  out  AWID  RAM port B address (odd)
ram_din_a  out  WID  RAM port A write data
ram_din_b  out  WID  RAM port B write data
ram_we_a  out  1  RAM port A write enable
ram_we_b  out  1  RAM port B write enable
ram_dout_a  in  WID  RAM port A read data (1-cycle latency, updated every cycle while we=0)
ram_dout_b  in  WID  RAM port B read data

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high.
- Reset and abort:
  - All outputs reset to 0: busy, done, s_ready, m_valid, m_data, RAM address/data/we.
  - All counters and valid flags clear; FSM goes to IDLE.
  - Reset mid-pass aborts immediately; the RAM is left partially written or read, with no done pulse.
- FSM states: IDLE, LOAD, UNLOAD.
  - IDLE -> LOAD on start_load.
  - IDLE -> UNLOAD on start_unload; if both starts are high, LOAD wins.
  - Starts are ignored while busy.
  - busy is registered and rises the cycle after the start is sampled.
- LOAD:
  - s_ready=1 throughout LOAD. A transfer is s_valid&s_ready; gaps in s_valid simply stall.
  - Word index w counts 0..DEPTH-1.
  - Even w: the word is latched into a hold register; no write.
  - Odd w: the next cycle drives ram_we_a=ram_we_b=1, ram_addr_a=w-1, ram_addr_b=w, ram_din_a=hold, ram_din_b=s_data. Both enables are 0 in every other cycle.
  - When w=DEPTH-1 is accepted, s_ready drops next cycle. The final write cycle carries done=1, and busy=0 from the following cycle.
- UNLOAD:
  - ram_we_a/b stay 0 and s_ready=0.
  - Pair counter p runs 0..DEPTH/2-1; the addresses are 2p and 2p+1.
  - A dv flag is set one cycle after an address change, meaning ram_dout reflects the current pair. The address is held until that pair is captured.
  - Pair buffer: buffer A/B words plus sel, with m_data = sel ? buf_b : buf_a.
  - Capture: when dv=1 and the buffer is empty or its B word is handshaked this cycle. On capture, load the buffer, set m_valid=1 and sel=0, advance p (if not last), and clear dv.
  - Handshake m_valid&m_ready: sel 0->1, or on B either a new capture or m_valid=0.
  - m_data and m_valid hold stable while m_valid&!m_ready.
  - Latency: start sampled at cycle 0, address 0/1 driven at cycle 1, dout at cycle 2, word 0 on m_data at cycle 3.
  - Sustained throughput with m_ready=1 is 1 word/cycle; all DEPTH words go out in DEPTH consecutive cycles.
  - After word DEPTH-1 is handshaked: done=1 next cycle, busy=0 and m_valid=0.
- Wrap: counters never wrap within a pass. A new pass restarts at address 0.

Test Plan:
- Load: start_load, stream s_data=i*3 (i=0..255) with s_valid=1 → 128 write cycles. Write k has addr_a=2k, addr_b=2k+1, din_a=6k, din_b=6k+3. done on the 128th write, then busy=0.
- Load with gaps: s_valid toggled 1/0 → same 128 writes and no write on an unpaired word. done only after word 255.
- Unload streaming: RAM model preloaded mem[i]=i^16'hA5A5, m_ready=1 → first m_valid at cycle 3 after start. Words 0..255 appear in order on 256 consecutive cycles, then done.
- Unload backpressure: m_ready random 50% → m_data stable while stalled, and exactly 256 ordered words with no duplicates or drops.
- Control: start_load and start_unload high together → LOAD. start_unload during LOAD is ignored, and the pass completes normally.
- Reset: assert rst at word 100 of an unload → all outputs 0 asynchronously. A fresh unload then restarts at word 0.
